// File: rtl/usb2_ep4_ts_reader.sv
// rtl/usb2_ep4_ts_reader.sv - EP4 bulk OUT buffer reader with TS sync framer and output skid FIFO
module usb2_ep4_ts_reader #(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_LEN     = 188
) (
    input  logic        phy_clk,
    input  logic        reset,
    input  logic        enable,
    output logic [8:0]  buf_out_addr,
    input  logic [7:0]  buf_out_q,
    input  logic [9:0]  buf_out_len,
    input  logic        buf_out_hasdata,
    output logic        buf_out_arm,
    input  logic        buf_out_arm_ack,
    output logic [7:0]  ts_data,
    output logic        ts_valid,
    output logic        ts_sop,
    input  logic        ts_ready,
    output logic        locked,
    output logic [15:0] pkt_cnt,
    output logic [15:0] sync_loss_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(TS_LEN);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_DRAIN    = 3'd2;
    localparam logic [2:0] S_ARM      = 3'd3;
    localparam logic [2:0] S_ARM_WAIT = 3'd4;

    logic [2:0]        st_q, st_d;
    logic [9:0]        len_q, len_d;
    logic [9:0]        rd_ptr_q, rd_ptr_d;
    logic [8:0]        addr_q, addr_d;
    logic              idle_entry_q, idle_entry_d;
    logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
    logic              lock_q, lock_d;
    logic [OW-1:0]     ofs_q, ofs_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic [15:0]       loss_q, loss_d;
    logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]     fifo_wp_q, fifo_wp_d;
    logic [PW-1:0]     fifo_rp_q, fifo_rp_d;
    logic [8:0]        fifo_mem [FIFO_DEPTH];

    logic [CW-1:0] inflight;
    logic [CW:0]   credit_used;
    logic          issue, ret, is_sync, push, push_sop, pop;
    logic [8:0]    head;

    // Every outstanding read has a reserved FIFO slot, so the FIFO cannot overflow.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_sr_q[i]);
        credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight};
        issue       = (st_q == S_READ) && (credit_used < (CW+1)'(FIFO_DEPTH));
        vld_sr_d    = vld_sr_q << 1;
        vld_sr_d[0] = issue;
    end

    always_comb begin
        st_d         = st_q;
        len_d        = len_q;
        rd_ptr_d     = rd_ptr_q;
        addr_d       = addr_q;
        idle_entry_d = 1'b0;
        case (st_q)
            S_IDLE: if (!idle_entry_q && enable && buf_out_hasdata) begin
                len_d    = buf_out_len;
                rd_ptr_d = '0;
                st_d     = (buf_out_len == 10'd0) ? S_ARM : S_READ;
            end
            S_READ: if (issue) begin
                addr_d   = rd_ptr_q[8:0];
                rd_ptr_d = rd_ptr_q + 10'd1;
                if (rd_ptr_q == len_q - 10'd1) st_d = S_DRAIN;
            end
            S_DRAIN:    if (inflight == '0) st_d = S_ARM;
            S_ARM:      if (buf_out_arm_ack) st_d = S_ARM_WAIT;
            S_ARM_WAIT: if (!buf_out_arm_ack) begin
                st_d         = S_IDLE;
                idle_entry_d = 1'b1;
            end
            default:    st_d = S_IDLE;
        endcase
    end

    // Framer acts on the byte returning from the read pipeline this cycle.
    always_comb begin
        ret       = vld_sr_q[RD_LAT-1];
        is_sync   = (buf_out_q == 8'h47);
        lock_d    = lock_q;
        ofs_d     = ofs_q;
        pkt_cnt_d = pkt_cnt_q;
        loss_d    = loss_q;
        push      = 1'b0;
        push_sop  = 1'b0;
        if (ret) begin
            if (!lock_q || ofs_q == '0) begin
                if (is_sync) begin
                    lock_d    = 1'b1;
                    ofs_d     = OW'(1);
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    push      = 1'b1;
                    push_sop  = 1'b1;
                end else if (lock_q) begin
                    lock_d = 1'b0;
                    loss_d = loss_q + 16'd1;
                end
            end else begin
                push  = 1'b1;
                ofs_d = (ofs_q == OW'(TS_LEN - 1)) ? '0 : ofs_q + OW'(1);
            end
        end
    end

    always_comb begin
        pop        = (fifo_cnt_q != '0) && ts_ready;
        fifo_cnt_d = fifo_cnt_q;
        fifo_wp_d  = fifo_wp_q;
        fifo_rp_d  = fifo_rp_q;
        if (push && !pop) fifo_cnt_d = fifo_cnt_q + CW'(1);
        if (pop && !push) fifo_cnt_d = fifo_cnt_q - CW'(1);
        if (push) fifo_wp_d = (fifo_wp_q == PW'(FIFO_DEPTH - 1)) ? '0 : fifo_wp_q + PW'(1);
        if (pop)  fifo_rp_d = (fifo_rp_q == PW'(FIFO_DEPTH - 1)) ? '0 : fifo_rp_q + PW'(1);
    end

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            st_q         <= S_IDLE;
            len_q        <= '0;
            rd_ptr_q     <= '0;
            addr_q       <= '0;
            idle_entry_q <= 1'b0;
            vld_sr_q     <= '0;
            lock_q       <= 1'b0;
            ofs_q        <= '0;
            pkt_cnt_q    <= '0;
            loss_q       <= '0;
            fifo_cnt_q   <= '0;
            fifo_wp_q    <= '0;
            fifo_rp_q    <= '0;
        end else begin
            st_q         <= st_d;
            len_q        <= len_d;
            rd_ptr_q     <= rd_ptr_d;
            addr_q       <= addr_d;
            idle_entry_q <= idle_entry_d;
            vld_sr_q     <= vld_sr_d;
            lock_q       <= lock_d;
            ofs_q        <= ofs_d;
            pkt_cnt_q    <= pkt_cnt_d;
            loss_q       <= loss_d;
            fifo_cnt_q   <= fifo_cnt_d;
            fifo_wp_q    <= fifo_wp_d;
            fifo_rp_q    <= fifo_rp_d;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (push) fifo_mem[fifo_wp_q] <= {push_sop, buf_out_q};
    end

    assign head          = fifo_mem[fifo_rp_q];
    assign ts_valid      = (fifo_cnt_q != '0);
    assign ts_data       = ts_valid ? head[7:0] : 8'h00;
    assign ts_sop        = ts_valid & head[8];
    assign buf_out_addr  = issue ? rd_ptr_q[8:0] : addr_q;
    assign buf_out_arm   = (st_q == S_ARM);
    assign locked        = lock_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign sync_loss_cnt = loss_q;
endmodule

// File: tb/tb_usb2_ep4_ts_reader.sv
// tb/tb_usb2_ep4_ts_reader.sv - self-checking bench for usb2_ep4_ts_reader
module tb_usb2_ep4_ts_reader;
    localparam int TS_LEN = 188;
    localparam int BOUND  = 6000;

    logic        phy_clk = 1'b0;
    logic        reset, enable, buf_out_hasdata, buf_out_arm, buf_out_arm_ack, ts_ready;
    logic        ts_valid, ts_sop, locked;
    logic [8:0]  buf_out_addr;
    logic [7:0]  buf_out_q, ts_data;
    logic [9:0]  buf_out_len;
    logic [15:0] pkt_cnt, sync_loss_cnt;

    always #5 phy_clk = ~phy_clk;

    usb2_ep4_ts_reader dut (
        .phy_clk(phy_clk), .reset(reset), .enable(enable),
        .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
        .buf_out_hasdata(buf_out_hasdata), .buf_out_arm(buf_out_arm),
        .buf_out_arm_ack(buf_out_arm_ack), .ts_data(ts_data), .ts_valid(ts_valid),
        .ts_sop(ts_sop), .ts_ready(ts_ready), .locked(locked), .pkt_cnt(pkt_cnt),
        .sync_loss_cnt(sync_loss_cnt)
    );

    // Endpoint buffer: two-cycle read latency, one-cycle arm acknowledge pulse.
    logic [7:0] ep_mem [512];
    logic [8:0] ep_a1;
    always @(posedge phy_clk) begin
        ep_a1     <= buf_out_addr;
        buf_out_q <= ep_mem[ep_a1];
    end
    always @(posedge phy_clk or posedge reset) begin
        if (reset) buf_out_arm_ack <= 1'b0;
        else       buf_out_arm_ack <= buf_out_arm & ~buf_out_arm_ack;
    end

    int checks = 0, failures = 0;
    logic [8:0] got_q[$], exp_q[$];
    logic [7:0] src[$], stream[$];
    int m_pos = -1, m_pkts = 0, m_loss = 0;
    int ready_pct = 100, arms = 0, bufs = 0, addr_moves = 0;
    logic arm_prev = 1'b0;
    logic [8:0] addr_prev = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: m_pos is the offset inside the current TS packet, -1 while hunting.
    function automatic void model_byte(input logic [7:0] b);
        if (m_pos <= 0) begin
            if (b == 8'h47) begin
                exp_q.push_back({1'b1, b});
                m_pkts++;
                m_pos = 1;
            end else if (m_pos == 0) begin
                m_loss++;
                m_pos = -1;
            end
        end else begin
            exp_q.push_back({1'b0, b});
            m_pos = (m_pos + 1) % TS_LEN;
        end
    endfunction

    function automatic void model_reset();
        m_pos = -1; m_pkts = 0; m_loss = 0;
        got_q.delete(); exp_q.delete();
    endfunction

    function automatic logic [7:0] rnd_byte(input bit no47);
        logic [7:0] b = 8'($urandom_range(255));
        if (no47 && b == 8'h47) b = 8'h48;
        return b;
    endfunction

    function automatic void gen_pkt(input logic [7:0] sync, input bit no47);
        stream.push_back(sync);
        for (int i = 1; i < TS_LEN; i++) stream.push_back(rnd_byte(no47));
    endfunction

    function automatic int first_mismatch();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic step();
        @(negedge phy_clk);
        ts_ready = ($urandom_range(99) < ready_pct);
        if (ts_valid && ts_ready) got_q.push_back({ts_sop, ts_data});
        if (buf_out_arm && !arm_prev) arms++;
        arm_prev = buf_out_arm;
        if (buf_out_addr !== addr_prev) addr_moves++;
        addr_prev = buf_out_addr;
        if (buf_out_arm) buf_out_hasdata = 1'b0;
    endtask

    task automatic load_src();
        foreach (src[i]) begin
            ep_mem[i] = src[i];
            model_byte(src[i]);
        end
        buf_out_len     = 10'(src.size());
        buf_out_hasdata = 1'b1;
    endtask

    task automatic run_buf(input string tag, output int first_valid, output int arm_at, output int last_valid);
        int t = 0;
        load_src();
        bufs++;
        first_valid = -1; arm_at = -1; last_valid = -1;
        while (arm_at < 0 && t < BOUND) begin
            step(); t++;
            if (ts_valid) begin
                if (first_valid < 0) first_valid = t;
                last_valid = t;
            end
            if (buf_out_arm) arm_at = t;
        end
        while ((ts_valid || buf_out_arm || buf_out_arm_ack) && t < BOUND) begin
            step(); t++;
            if (ts_valid) last_valid = t;
        end
        check({tag, "_done_in_bound"}, (t < BOUND), 1);
        repeat (3) step();
        src.delete();
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        check({tag, "_first_bad_idx"}, first_mismatch(), -1);
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        int fv, aa, lv, a0, t;
        foreach (ep_mem[i]) ep_mem[i] = 8'h00;
        reset = 1'b1; enable = 1'b1; buf_out_len = '0; buf_out_hasdata = 1'b0; ts_ready = 1'b1;
        repeat (3) step();
        check("rst_valid", ts_valid, 0);
        check("rst_sop", ts_sop, 0);
        check("rst_data", ts_data, 0);
        check("rst_addr", buf_out_addr, 0);
        check("rst_arm", buf_out_arm, 0);
        check("rst_locked", locked, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_loss_cnt", sync_loss_cnt, 0);
        reset = 1'b0;
        step();

        // Single aligned packet at full rate
        gen_pkt(8'h47, 1'b0);
        while (stream.size() > 0) src.push_back(stream.pop_front());
        run_buf("single", fv, aa, lv);
        check("single_first_byte_lat", fv, 4);
        check("single_arm_lat", aa, TS_LEN + 4);
        check("single_contiguous", lv - fv + 1, TS_LEN);
        check("single_locked", locked, (m_pos >= 0));
        check("single_pkt_cnt", pkt_cnt, m_pkts);
        check("single_arms", arms, bufs);
        cmp_stream("single");

        // Six packets spread over 512 + 512 + 104 byte buffers
        for (int p = 0; p < 6; p++) gen_pkt(8'h47, 1'b0);
        for (int b = 0; b < 3; b++) begin
            int n = (b < 2) ? 512 : 104;
            repeat (n) src.push_back(stream.pop_front());
            run_buf("span", fv, aa, lv);
        end
        check("span_pkt_cnt", pkt_cnt, m_pkts);
        check("span_loss_cnt", sync_loss_cnt, m_loss);
        check("span_arms", arms, bufs);
        cmp_stream("span");

        // Hunt from garbage, lose sync on a 0x46, reacquire
        reset = 1'b1; step(); step(); reset = 1'b0; step();
        model_reset();
        for (int i = 0; i < 5; i++) stream.push_back(rnd_byte(1'b1));
        gen_pkt(8'h47, 1'b1);
        gen_pkt(8'h46, 1'b1);
        gen_pkt(8'h47, 1'b1);
        repeat (512) src.push_back(stream.pop_front());
        run_buf("hunt", fv, aa, lv);
        while (stream.size() > 0) src.push_back(stream.pop_front());
        run_buf("hunt", fv, aa, lv);
        check("hunt_pkt_cnt", pkt_cnt, m_pkts);
        check("hunt_loss_cnt", sync_loss_cnt, m_loss);
        check("hunt_locked", locked, (m_pos >= 0));
        cmp_stream("hunt");

        // Random backpressure on a 512-byte buffer
        ready_pct = 30;
        for (int p = 0; p < 3; p++) gen_pkt(8'h47, 1'b0);
        repeat (512) src.push_back(stream.pop_front());
        stream.delete();
        run_buf("bp", fv, aa, lv);
        check("bp_pkt_cnt", pkt_cnt, m_pkts);
        check("bp_arms", arms, bufs);
        cmp_stream("bp");
        ready_pct = 100;

        // Zero-length buffer is re-armed without output
        a0 = arms;
        run_buf("zlen", fv, aa, lv);
        check("zlen_arms", arms, a0 + 1);
        check("zlen_no_valid", fv, -1);

        // Enable low blocks a waiting buffer
        a0 = arms;
        enable = 1'b0; buf_out_len = 10'd10; buf_out_hasdata = 1'b1; addr_moves = 0;
        repeat (40) step();
        check("en_addr_moves", addr_moves, 0);
        check("en_arms", arms, a0);
        check("en_no_output", got_q.size(), 0);
        buf_out_hasdata = 1'b0; enable = 1'b1;
        repeat (3) step();

        // Reset in the middle of a buffer
        for (int i = 0; i < 52; i++) src.push_back(rnd_byte(1'b0));
        gen_pkt(8'h47, 1'b0);
        for (int i = 0; i < 60; i++) stream.push_back(rnd_byte(1'b0));
        while (stream.size() > 0) src.push_back(stream.pop_front());
        load_src();
        src.delete();
        t = 0;
        while (got_q.size() < 100 && t < BOUND) begin step(); t++; end
        check("mid_reached_100", (t < BOUND), 1);
        check("mid_prefix_bad_idx", first_mismatch(), -1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", ts_valid, 0);
        check("mid_rst_sop", ts_sop, 0);
        check("mid_rst_data", ts_data, 0);
        check("mid_rst_addr", buf_out_addr, 0);
        check("mid_rst_arm", buf_out_arm, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_pkt_cnt", pkt_cnt, 0);
        check("mid_rst_loss_cnt", sync_loss_cnt, 0);
        step(); step();
        model_reset();
        gen_pkt(8'h47, 1'b0);
        while (stream.size() > 0) src.push_back(stream.pop_front());
        reset = 1'b0;
        run_buf("after_rst", fv, aa, lv);
        check("after_rst_pkt_cnt", pkt_cnt, m_pkts);
        check("after_rst_locked", locked, (m_pos >= 0));
        check("after_rst_arms", arms, bufs);
        cmp_stream("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb2_ep4_ts_reader.md
# usb2_ep4_ts_reader

Drains host-to-device Transport Stream packets from the EP4 bulk OUT endpoint buffer on its external read port and turns them into a byte stream with TS packet framing. It sits beside `usb2_protocol` on `phy_clk`, on the far side of the `ep4_buf_out_*` interface. It reads each committed USB packet, re-arms the buffer, and hunts for and tracks 0x47 sync across USB packet boundaries. Downstream logic (TS output or CI path) consumes bytes with valid/ready backpressure.

## Interface
Parameters:
- `RD_LAT`, 2, cycles from `buf_out_addr` to valid `buf_out_q`
- `FIFO_DEPTH`, 4, output skid FIFO entries; must be ≥ `RD_LAT`+1
- `TS_LEN`, 188, TS packet length in bytes

Ports (one clock; reset is asynchronous and active-high):
- `phy_clk` in 1: USB PHY clock, the only clock
- `reset` in 1: asynchronous, active-high
- `enable` in 1: when low, no new buffer is accepted; the current buffer still completes
- `buf_out_addr` out 9: EP4 buffer read address
- `buf_out_q` in 8: EP4 buffer read data
- `buf_out_len` in 10: byte count of the committed packet
- `buf_out_hasdata` in 1: a packet is committed and waiting
- `buf_out_arm` out 1: release the buffer back to the endpoint
- `buf_out_arm_ack` in 1: endpoint acknowledges the release
- `ts_data` out 8: stream byte
- `ts_valid` out 1: `ts_data` is valid
- `ts_sop` out 1: byte is a TS packet start (0x47 at offset 0)
- `ts_ready` in 1: downstream accepts the byte when `ts_valid` & `ts_ready`
- `locked` out 1: framer is in LOCK
- `pkt_cnt` out 16: TS packets started in LOCK; wraps
- `sync_loss_cnt` out 16: LOCK→HUNT transitions; wraps

## Operation
- Buffer FSM states: IDLE, READ, DRAIN, ARM, ARM_WAIT.
- **IDLE.** If `enable` & `buf_out_hasdata`: latch `len` = `buf_out_len`, clear `rd_ptr`.
  - `len` = 0 → go to ARM.
  - Otherwise → go to READ.
- **READ.** Issue a read (`buf_out_addr` = `rd_ptr`, `rd_ptr`+1) in any cycle where `fifo_count` + `inflight` < `FIFO_DEPTH`.
  - Go to DRAIN after issuing address `len`-1.
- **DRAIN.** Wait for `inflight` = 0, then go to ARM.
- **ARM.** Hold `buf_out_arm` = 1 until `buf_out_arm_ack` = 1, then drop arm and go to ARM_WAIT.
- **ARM_WAIT.** Wait for `buf_out_arm_ack` = 0, then go to IDLE. `hasdata` is not sampled on the IDLE entry cycle.
- **Read pipeline.** An `RD_LAT`-deep valid shift register tags each issued read. A returning byte enters the framer, and only accepted bytes are written to the FIFO along with their sop bit.
- **Framer states: HUNT, LOCK.** Byte offset counter `ofs` runs 0..`TS_LEN`-1.
  - HUNT: bytes ≠ 0x47 are discarded. On 0x47: go to LOCK, `ofs` = 1, write the byte with sop = 1, `pkt_cnt`+1.
  - LOCK, `ofs` ≠ 0: write the byte with sop = 0; `ofs`+1, wrapping `TS_LEN`-1→0.
  - LOCK, `ofs` = 0, byte = 0x47: write with sop = 1, `pkt_cnt`+1.
  - LOCK, `ofs` = 0, byte ≠ 0x47: discard, go to HUNT, `sync_loss_cnt`+1.
- Framer state and `ofs` persist across USB buffers. `enable` low does not reset the framer.
- **FIFO.** `ts_valid` = FIFO non-empty; `ts_data`/`ts_sop` come from the head. Pop on `ts_valid` & `ts_ready`. Simultaneous push and pop leaves the count unchanged. The credit rule guarantees the FIFO never overflows.

## Timing
- **Reset values:** FSM IDLE, framer HUNT; `buf_out_addr` 0, `buf_out_arm` 0, `ts_valid` 0, `ts_sop` 0, `ts_data` 0, `locked` 0, counters 0, FIFO empty, `inflight` 0.
- **Reset mid-operation:** everything returns immediately to the reset values, and buffer contents are abandoned. The endpoint is not re-armed by this block.
- **Latency:**
  - `hasdata` sampled in IDLE → first address 1 cycle later.
  - Byte at FIFO head `RD_LAT`+1 cycles after its address.
- **Throughput:** 1 byte/cycle sustained with `ts_ready` = 1.
- **Stall:** when `ts_ready` = 0, reads stop once `fifo_count` + `inflight` = `FIFO_DEPTH`. No byte is lost or duplicated.
- **Buffer turnaround:** with `ts_ready` = 1 and arm_ack answered in 1 cycle, N bytes take N+`RD_LAT`+5 cycles from `hasdata` to IDLE.
- `buf_out_addr` holds its last value when no read is issued.
- All counters and the framer update on the cycle the byte returns from the read pipeline.

## Test plan
- **Single packet:** one 188-byte packet starting 0x47, `ts_ready` = 1 → 188 contiguous `ts_valid` bytes, `ts_sop` on the first only; `pkt_cnt` = 1; `locked` = 1; one arm/ack handshake; first byte 4 cycles after `hasdata`.
- **Packet spanning buffers:** 512+512+104 byte buffers carrying 6 TS packets (1128 bytes) → byte-exact output, 6 sops, `sync_loss_cnt` = 0, 3 arms.
- **Sync hunt and loss:** 5 garbage bytes, then a valid packet, then a packet with a corrupted sync byte 0x46, then a valid packet → garbage discarded; byte 0x46 and the 187 bytes after it dropped; `sync_loss_cnt` = 1, `pkt_cnt` = 2.
- **Backpressure:** `ts_ready` random at 30% duty on a 512-byte buffer → output equals input in order; FIFO never exceeds 4 entries.
- **Zero-length and enable:**
  - `len` = 0 → arm with no `ts_valid`.
  - `enable` low with `hasdata` high → no address issued and no arm.
- **Reset mid-buffer:** assert `reset` after 100 bytes → outputs return to reset values within the same cycle; after release the next buffer is read from address 0 and the framer starts in HUNT.
